pipelined_sat_addsub: RTL and testbench

PIPELINED_SAT_ADDSUB -- requirements
Module: pipelined_sat_addsub

---
 rtl/pipelined_sat_addsub.sv | 120 ++++++++++++
 tb/tb_pipelined_sat_addsub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_sat_addsub.sv
// Two-stage pipelined add/subtract with optional signed saturation and NZVC flags.
// Stage 1 adds the low halves; stage 2 finishes the upper half, saturates and forms flags.
module pipelined_sat_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);

  localparam int unsigned H = WIDTH / 2;

  logic             s1_valid_q, s1_valid_d;
  logic [H-1:0]     s1_lo_sum_q, s1_lo_sum_d;
  logic             s1_lo_carry_q, s1_lo_carry_d;
  logic [H-1:0]     s1_a_hi_q, s1_a_hi_d;
  logic [H-1:0]     s1_bp_hi_q, s1_bp_hi_d;
  logic             s1_sat_en_q, s1_sat_en_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flag_q, flag_d;

  logic             s1_load, s2_load;
  logic [WIDTH-1:0] b_eff;
  logic [H:0]       lo_add;
  logic [H:0]       hi_add;
  logic [WIDTH-1:0] raw;
  logic             ovf;
  logic [WIDTH-1:0] sat_res;

  // in_ready is forced low during reset so nothing is accepted into a flushing pipe.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = rst_n && s1_load;
  end

  always_comb begin
    b_eff  = sub ? ~b : b;
    lo_add = {1'b0, a[H-1:0]} + {1'b0, b_eff[H-1:0]} + {{H{1'b0}}, sub};

    s1_valid_d    = s1_valid_q;
    s1_lo_sum_d   = s1_lo_sum_q;
    s1_lo_carry_d = s1_lo_carry_q;
    s1_a_hi_d     = s1_a_hi_q;
    s1_bp_hi_d    = s1_bp_hi_q;
    s1_sat_en_d   = s1_sat_en_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_lo_sum_d   = lo_add[H-1:0];
        s1_lo_carry_d = lo_add[H];
        s1_a_hi_d     = a[WIDTH-1:H];
        s1_bp_hi_d    = b_eff[WIDTH-1:H];
        s1_sat_en_d   = sat_en;
      end
    end
  end

  always_comb begin
    hi_add = {1'b0, s1_a_hi_q} + {1'b0, s1_bp_hi_q} + {{H{1'b0}}, s1_lo_carry_q};
    raw    = {hi_add[H-1:0], s1_lo_sum_q};
    ovf    = (s1_a_hi_q[H-1] == s1_bp_hi_q[H-1]) && (raw[WIDTH-1] != s1_a_hi_q[H-1]);
    if (s1_sat_en_q && ovf) begin
      sat_res = s1_a_hi_q[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_res = raw;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flag_d     = flag_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = sat_res;
        flag_d   = {sat_res[WIDTH-1], (sat_res == '0), ovf, hi_add[H]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_sum_q   <= '0;
      s1_lo_carry_q <= 1'b0;
      s1_a_hi_q     <= '0;
      s1_bp_hi_q    <= '0;
      s1_sat_en_q   <= 1'b0;
      s2_valid_q    <= 1'b0;
      result_q      <= '0;
      flag_q        <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_sum_q   <= s1_lo_sum_d;
      s1_lo_carry_q <= s1_lo_carry_d;
      s1_a_hi_q     <= s1_a_hi_d;
      s1_bp_hi_q    <= s1_bp_hi_d;
      s1_sat_en_q   <= s1_sat_en_d;
      s2_valid_q    <= s2_valid_d;
      result_q      <= result_d;
      flag_q        <= flag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_pipelined_sat_addsub.sv
// Self-checking bench: directed corner cases plus randomized traffic against a scoreboard model.
module tb_pipelined_sat_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        sub, sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flag;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_acc = 0;
  int unsigned n_out = 0;

  logic [19:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_res;
  logic [3:0]  prev_flag;

  pipelined_sat_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic decides overflow, unsigned compare decides carry.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic sat);
    int sx, sy, tv, ux, uy;
    logic ov, c;
    logic [15:0] r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    tv = s ? sx - sy : sx + sy;
    ov = (tv > 32767) || (tv < -32768);
    c  = s ? (ux >= uy) : (ux + uy > 65535);
    r  = tv[15:0];
    if (sat && ov) r = (sx < 0) ? 16'h8000 : 16'h7FFF;
    return {r[15], (r == 16'h0000), ov, c, r};
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor samples handshakes mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_result", 32'(result), 32'(prev_res));
        check_eq("hold_flag", 32'(flag), 32'(prev_flag));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, sat_en));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check_eq("sb_result", 32'(result), 32'(e[15:0]));
          check_eq("sb_flag", 32'(flag), 32'(e[19:16]));
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_flag  = flag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic sat,
                          input logic [15:0] er, input logic [3:0] ef);
    out_ready = 1'b1;
    in_valid = 1'b1; a = x; b = y; sub = s; sat_en = sat;
    check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq({name, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check_eq({name, "_lat2"}, 32'(out_valid), 32'd1);
    check_eq({name, "_result"}, 32'(result), 32'(er));
    check_eq({name, "_flag"}, 32'(flag), 32'(ef));
    tick();
  endtask

  logic [15:0] st_a[4] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h0005};
  logic [15:0] st_b[4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0007};
  logic        st_s[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int unsigned base_acc, base_out, prev_out, k, target, cyc;
    int first, last;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat_en = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    check_eq("rel_out_valid", 32'(out_valid), 32'd0);
    check_eq("rel_result", 32'(result), 32'd0);
    check_eq("rel_flag", 32'(flag), 32'd0);
    tick();

    directed("max_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0010);
    directed("max_wrap",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1010);
    directed("min_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1011);
    directed("zero_sub",  16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'b0101);
    directed("half_carry",16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000);

    // Backpressure: four back-to-back sets with the consumer stalled.
    base_acc = n_acc; base_out = n_out;
    out_ready = 1'b0; sat_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      k = n_acc - base_acc;
      in_valid = (k < 4);
      if (k < 4) begin a = st_a[k]; b = st_b[k]; sub = st_s[k]; end
      check_eq($sformatf("stall_ready%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq("stall_accepts", n_acc - base_acc, 32'd2);
    out_ready = 1'b1; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      k = n_acc - base_acc;
      in_valid = (k < 4);
      if (k < 4) begin a = st_a[k]; b = st_b[k]; sub = st_s[k]; end
      prev_out = n_out;
      tick();
      if (n_out != prev_out) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    in_valid = 1'b0;
    check_eq("stall_outputs", n_out - base_out, 32'd4);
    check_eq("stall_back2back", 32'(last - first), 32'd3);

    // Reset with two operations in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h0011; b = 16'h0022; sub = 1'b0;
    tick();
    a = 16'h0033; b = 16'h0044;
    tick();
    in_valid = 1'b0;
    check_eq("flight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("flight_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_result", 32'(result), 32'd0);
    check_eq("flush_flag", 32'(flag), 32'd0);
    base_out = n_out; out_ready = 1'b1;
    repeat (5) tick();
    check_eq("no_stale", n_out - base_out, 32'd0);

    // Randomized traffic with random backpressure.
    target = n_acc + 10000; cyc = 0;
    while (n_acc < target && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rnd_op();
      b         = rnd_op();
      sub       = 1'($urandom);
      sat_en    = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      cyc++;
    end
    check_eq("rand_accepted", 32'(n_acc >= target), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    check_eq("drain_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
